// File: rtl/sms_rom_mapper.sv
// sms_rom_mapper
//   Sega-style cartridge mapper and ROM read sequencer. Holds the $FFFC-$FFFF
//   paging registers, translates 16-bit CPU addresses into physical ROM
//   addresses, and runs a three-state read sequence against a synchronous ROM
//   that has one cycle of read latency.
//
// Ports
//   i_clock      system clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   i_cpu_addr   CPU address, sampled with i_rd_req / i_wr_req
//   i_cpu_din    CPU write data, sampled with i_wr_req
//   i_rd_req     one-cycle read request (ignored while o_busy=1)
//   i_wr_req     one-cycle write request (paging registers, accepted in any state)
//   o_rd_data    read result, valid with o_rd_ack and held afterwards
//   o_rd_ack     one-cycle read-complete pulse
//   o_rd_hit     1 = ROM-space read, 0 = non-ROM (o_rd_data = 8'hFF)
//   o_busy       a read is in flight
//   o_rom_addr   registered address to the synchronous ROM
//   i_rom_q      ROM data, valid the cycle after o_rom_addr is captured by the ROM
//   o_bank_ctrl  $FFFC control register, exported for cart-RAM logic
module sms_rom_mapper #(
  parameter int ROM_AW = 19
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic [15:0]       i_cpu_addr,
  input  logic [7:0]        i_cpu_din,
  input  logic              i_rd_req,
  input  logic              i_wr_req,
  output logic [7:0]        o_rd_data,
  output logic              o_rd_ack,
  output logic              o_rd_hit,
  output logic              o_busy,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [7:0]        i_rom_q,
  output logic [7:0]        o_bank_ctrl
);

  localparam int NB = ROM_AW - 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [7:0]        r_bank_ctrl;
  logic [7:0]        r_bank0;
  logic [7:0]        r_bank1;
  logic [7:0]        r_bank2;
  logic [ROM_AW-1:0] r_rom_addr;
  logic [7:0]        r_rd_data;
  logic              r_rd_ack;
  logic              r_rd_hit;
  logic              r_pend_hit;

  logic [NB-1:0]     w_bank_sel;
  logic [ROM_AW-1:0] w_map_addr;
  logic              w_map_hit;
  logic              w_accept;

  // Address translation uses the current (pre-write) bank registers, so a
  // write in the same cycle as an accepted read does not affect that read.
  always_comb begin
    w_bank_sel = r_bank0[NB-1:0];
    case (i_cpu_addr[15:14])
      2'b01:   w_bank_sel = r_bank1[NB-1:0];
      2'b10:   w_bank_sel = r_bank2[NB-1:0];
      default: w_bank_sel = r_bank0[NB-1:0];
    endcase
    w_map_hit = (i_cpu_addr[15:14] != 2'b11);
    // First 1 KB is fixed to physical page 0 regardless of bank0.
    if (i_cpu_addr[15:10] == 6'd0) begin
      w_map_addr = {{(ROM_AW-10){1'b0}}, i_cpu_addr[9:0]};
    end else begin
      w_map_addr = {w_bank_sel, i_cpu_addr[13:0]};
    end
  end

  assign w_accept = i_rd_req && (r_state == ST_IDLE);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = ST_ISSUE;
      ST_ISSUE: w_state_next = ST_CAPT;
      ST_CAPT:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bank_ctrl <= 8'h00;
      r_bank0     <= 8'h00;
      r_bank1     <= 8'h01;
      r_bank2     <= 8'h02;
      r_rom_addr  <= '0;
      r_rd_data   <= 8'hFF;
      r_rd_ack    <= 1'b0;
      r_rd_hit    <= 1'b0;
      r_pend_hit  <= 1'b0;
    end else begin
      r_rd_ack <= 1'b0;

      if (i_wr_req) begin
        case (i_cpu_addr)
          16'hFFFC: r_bank_ctrl <= i_cpu_din;
          16'hFFFD: r_bank0     <= i_cpu_din;
          16'hFFFE: r_bank1     <= i_cpu_din;
          16'hFFFF: r_bank2     <= i_cpu_din;
          default: ;
        endcase
      end

      if (w_accept) begin
        r_pend_hit <= w_map_hit;
        // Non-ROM reads leave the ROM address untouched.
        if (w_map_hit) r_rom_addr <= w_map_addr;
      end

      if (r_state == ST_CAPT) begin
        r_rd_ack  <= 1'b1;
        r_rd_hit  <= r_pend_hit;
        r_rd_data <= r_pend_hit ? i_rom_q : 8'hFF;
      end
    end
  end

  assign o_busy      = (r_state != ST_IDLE);
  assign o_rom_addr  = r_rom_addr;
  assign o_rd_data   = r_rd_data;
  assign o_rd_ack    = r_rd_ack;
  assign o_rd_hit    = r_rd_hit;
  assign o_bank_ctrl = r_bank_ctrl;

endmodule

// File: tb/tb_sms_rom_mapper.sv
// tb_sms_rom_mapper
//   Randomized bench for sms_rom_mapper with a synchronous ROM model and a
//   behavioural mapping model computed from plain address arithmetic.
module tb_sms_rom_mapper;

  localparam int ROM_AW = 19;
  localparam int NB     = ROM_AW - 14;

  logic              clk;
  logic              reset_n;
  logic [15:0]       cpu_addr;
  logic [7:0]        cpu_din;
  logic              rd_req;
  logic              wr_req;
  logic [7:0]        rd_data;
  logic              rd_ack;
  logic              rd_hit;
  logic              busy;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_q;
  logic [7:0]        bank_ctrl;

  logic [7:0] rom_mem [0:(1<<ROM_AW)-1];

  // Reference state: paging registers (ctrl, bank0, bank1, bank2) and last ROM address.
  logic [7:0] m_bank [4];
  int         m_rom_addr;

  int checks;
  int failures;

  sms_rom_mapper #(.ROM_AW(ROM_AW)) dut (
    .i_clock     (clk),
    .i_reset_n   (reset_n),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_din   (cpu_din),
    .i_rd_req    (rd_req),
    .i_wr_req    (wr_req),
    .o_rd_data   (rd_data),
    .o_rd_ack    (rd_ack),
    .o_rd_hit    (rd_hit),
    .o_busy      (busy),
    .o_rom_addr  (rom_addr),
    .i_rom_q     (rom_q),
    .o_bank_ctrl (bank_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM, one cycle of read latency.
  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bank[0]  = 8'h00;
    m_bank[1]  = 8'h00;
    m_bank[2]  = 8'h01;
    m_bank[3]  = 8'h02;
    m_rom_addr = 0;
  endtask

  task automatic model_write(input logic [15:0] a, input logic [7:0] d);
    if (a >= 16'hFFFC) m_bank[a - 16'hFFFC] = d;
  endtask

  // Physical address from page arithmetic: 16 KB slots, slot n uses bank n.
  task automatic model_map(input logic [15:0] a, output bit hit, output int phys);
    int slot;
    int bank;
    slot = int'(a) / 16384;
    hit  = (slot < 3);
    if (int'(a) < 1024) begin
      phys = int'(a);
    end else begin
      bank = int'(m_bank[slot < 3 ? slot + 1 : 1]) % (1 << NB);
      phys = bank * 16384 + int'(a) % 16384;
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_addr = a;
    cpu_din  = d;
    wr_req   = 1'b1;
    @(negedge clk);
    wr_req = 1'b0;
    model_write(a, d);
    check_val("wr_bank_ctrl", 32'(bank_ctrl), 32'(m_bank[0]));
    $display("WR addr=%04h data=%02h", a, d);
  endtask

  // One read transaction. same_wr: write (a, wd) in the accept cycle.
  // mid_wr: write (wa, wd) during ISSUE. extra_rd: rd_req during ISSUE (must be dropped).
  task automatic do_read(input logic [15:0] a, input bit same_wr, input bit mid_wr,
                         input bit extra_rd, input logic [15:0] wa, input logic [7:0] wd);
    bit         hit;
    int         phys;
    logic [7:0] exp_data;
    model_map(a, hit, phys);
    if (hit) m_rom_addr = phys;
    exp_data = hit ? rom_mem[phys] : 8'hFF;

    @(negedge clk);
    cpu_addr = a;
    rd_req   = 1'b1;
    if (same_wr) begin
      cpu_din = wd;
      wr_req  = 1'b1;
    end
    @(posedge clk);  // E0
    #1;
    if (same_wr) model_write(a, wd);
    check_val("e0_rom_addr", 32'(rom_addr), 32'(m_rom_addr));
    check_val("e0_busy", 32'(busy), 32'd1);
    check_val("e0_ack", 32'(rd_ack), 32'd0);

    @(negedge clk);
    rd_req = 1'b0;
    wr_req = 1'b0;
    if (mid_wr || extra_rd) cpu_addr = mid_wr ? wa : 16'($urandom);
    if (mid_wr) begin
      cpu_din = wd;
      wr_req  = 1'b1;
    end
    if (extra_rd) rd_req = 1'b1;
    @(posedge clk);  // E1
    #1;
    check_val("e1_ack", 32'(rd_ack), 32'd0);
    check_val("e1_rom_addr", 32'(rom_addr), 32'(m_rom_addr));

    @(negedge clk);
    if (mid_wr) model_write(wa, wd);
    rd_req = 1'b0;
    wr_req = 1'b0;
    @(posedge clk);  // E2
    #1;
    check_val("e2_ack", 32'(rd_ack), 32'd1);
    check_val("e2_hit", 32'(rd_hit), 32'(hit));
    check_val("e2_data", 32'(rd_data), 32'(exp_data));
    check_val("e2_busy", 32'(busy), 32'd0);

    @(posedge clk);  // E3
    #1;
    check_val("e3_ack", 32'(rd_ack), 32'd0);
    check_val("e3_data_hold", 32'(rd_data), 32'(exp_data));
    check_val("e3_busy", 32'(busy), 32'd0);
    check_val("e3_bank_ctrl", 32'(bank_ctrl), 32'(m_bank[0]));
    $display("RD addr=%04h rom_addr=%05h data=%02h hit=%0d sw=%0d mw=%0d xr=%0d",
             a, rom_addr, rd_data, rd_hit, same_wr, mid_wr, extra_rd);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check_val({tag, "_rd_data"}, 32'(rd_data), 32'hFF);
    check_val({tag, "_ack"}, 32'(rd_ack), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_bank_ctrl"}, 32'(bank_ctrl), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    cpu_addr = 16'h0000;
    cpu_din  = 8'h00;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    for (int i = 0; i < (1 << ROM_AW); i++) rom_mem[i] = 8'($urandom);
    rom_mem[19'h04123] = 8'h5A;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("idle");
    $display("RESET released");

    // Default banks: one read per slot.
    do_read(16'h0123, 0, 0, 0, 16'h0, 8'h0);
    do_read(16'h1234, 0, 0, 0, 16'h0, 8'h0);
    do_read(16'h4123, 0, 0, 0, 16'h0, 8'h0);
    check_val("rom_4123", 32'(rd_data), 32'h5A);
    do_read(16'hBFFF, 0, 0, 0, 16'h0, 8'h0);

    // Bank 2 load and modulo-2^NB wrap.
    do_write(16'hFFFF, 8'h05);
    do_read(16'h8010, 0, 0, 0, 16'h0, 8'h0);
    check_val("bank2_map", 32'(rom_addr), 32'h14010);
    do_write(16'hFFFF, 8'h25);
    do_read(16'h8010, 0, 0, 0, 16'h0, 8'h0);
    check_val("bank2_wrap", 32'(rom_addr), 32'h14010);

    // Bank 0 vs fixed first 1 KB.
    do_write(16'hFFFD, 8'h07);
    do_read(16'h0200, 0, 0, 0, 16'h0, 8'h0);
    check_val("fixed_1k", 32'(rom_addr), 32'h00200);
    do_read(16'h0400, 0, 0, 0, 16'h0, 8'h0);
    check_val("bank0_map", 32'(rom_addr), 32'h1C400);

    // Non-ROM read with a dropped request while busy.
    do_read(16'hC000, 0, 0, 1, 16'h0, 8'h0);
    check_val("nonrom_addr_kept", 32'(rom_addr), 32'h1C400);
    // Write to ctrl in the same cycle as a read of $FFFC.
    do_read(16'hFFFC, 1, 0, 0, 16'h0, 8'hA5);
    // Bank write during the in-flight read.
    do_read(16'h4567, 0, 1, 0, 16'hFFFE, 8'h1F);
    do_read(16'h4567, 0, 0, 0, 16'h0, 8'h0);

    // Reset in ISSUE: aborted, no ack.
    @(negedge clk);
    cpu_addr = 16'h5555;
    rd_req   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd_req  = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_val("abort_no_ack", 32'(rd_ack), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_val("post_abort_no_ack", 32'(rd_ack), 32'd0);
    end
    $display("RESET mid-read");
    do_read(16'h8001, 0, 0, 0, 16'h0, 8'h0);
    do_read(16'h4001, 0, 0, 0, 16'h0, 8'h0);

    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      int          op;
      logic [15:0] a;
      logic [15:0] wa;
      logic [7:0]  d;
      op = $urandom_range(0, 9);
      d  = 8'($urandom);
      wa = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'hFFFC + 16'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       a = 16'($urandom_range(0, 16'h07FF));
        default: a = 16'($urandom);
      endcase
      if (op < 3) begin
        do_write(wa, d);
      end else if (op == 3) begin
        do_read(16'hFFFC + 16'($urandom_range(0, 3)), 1, 0, 0, 16'h0, d);
      end else begin
        do_read(a, 0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), wa, d);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end

endmodule
